// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter serialising NUM_CACHES cache ports onto one Memory port.
// One transaction in flight; reads wait for Memory (or time out), writes ack after one request cycle.
module mem_bus_arbiter #(
  parameter int NUM_CACHES     = 4,
  parameter int ADDRESS_WIDTH  = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_CACHES-1:0]                 req_valid,
  input  logic [NUM_CACHES-1:0]                 req_write,
  input  logic [NUM_CACHES*ADDRESS_WIDTH-1:0]   req_addr,
  input  logic [NUM_CACHES*DATA_WIDTH-1:0]      req_data,
  output logic [NUM_CACHES-1:0]                 req_ready,
  output logic [NUM_CACHES-1:0]                 resp_valid,
  output logic                                  resp_error,
  output logic [DATA_WIDTH-1:0]                 resp_data,
  output logic                                  snoop_valid,
  output logic [$clog2(NUM_CACHES)-1:0]         snoop_id,
  output logic [ADDRESS_WIDTH-1:0]              snoop_addr,
  output logic                                  snoop_write,
  output logic                                  mem_req_valid,
  output logic [ADDRESS_WIDTH-1:0]              mem_req_addr,
  output logic                                  mem_req_write,
  output logic [DATA_WIDTH-1:0]                 mem_req_data,
  input  logic                                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]                 mem_resp_data
);

  localparam int ID_W = $clog2(NUM_CACHES);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_CACHES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT} state_t;

  state_t                    state_q, state_d;
  logic [ID_W-1:0]           rr_q, rr_d;
  logic [ID_W-1:0]           gnt_q, gnt_d;
  logic [TO_W-1:0]           timeout_q, timeout_d;
  logic [NUM_CACHES-1:0]     req_ready_q, req_ready_d;
  logic [NUM_CACHES-1:0]     resp_valid_q, resp_valid_d;
  logic                      resp_error_q, resp_error_d;
  logic [DATA_WIDTH-1:0]     resp_data_q, resp_data_d;
  logic                      snoop_valid_q, snoop_valid_d;
  logic [ID_W-1:0]           snoop_id_q, snoop_id_d;
  logic [ADDRESS_WIDTH-1:0]  snoop_addr_q, snoop_addr_d;
  logic                      snoop_write_q, snoop_write_d;
  logic                      mem_req_valid_q, mem_req_valid_d;
  logic [ADDRESS_WIDTH-1:0]  mem_req_addr_q, mem_req_addr_d;
  logic                      mem_req_write_q, mem_req_write_d;
  logic [DATA_WIDTH-1:0]     mem_req_data_q, mem_req_data_d;

  logic                      win_found;
  logic [ID_W-1:0]           win_idx;
  logic [ID_W-1:0]           cand;
  logic [ADDRESS_WIDTH-1:0]  win_addr;
  logic [DATA_WIDTH-1:0]     win_data;
  logic                      win_write;

  // Search starts one past the last winner, so a port just served ranks last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = rr_q;
    for (int i = 0; i < NUM_CACHES; i++) begin
      cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_addr  = req_addr[int'(win_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    win_data  = req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
    win_write = req_write[win_idx];
  end

  always_comb begin
    state_d         = state_q;
    rr_d            = rr_q;
    gnt_d           = gnt_q;
    timeout_d       = timeout_q;
    req_ready_d     = '0;
    resp_valid_d    = '0;
    resp_error_d    = 1'b0;
    resp_data_d     = resp_data_q;
    snoop_valid_d   = 1'b0;
    snoop_id_d      = snoop_id_q;
    snoop_addr_d    = snoop_addr_q;
    snoop_write_d   = snoop_write_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_write_d = mem_req_write_q;
    mem_req_data_d  = mem_req_data_q;

    case (state_q)
      IDLE: begin
        mem_req_valid_d = 1'b0;
        timeout_d       = '0;
        if (win_found) begin
          gnt_d                = win_idx;
          rr_d                 = win_idx;
          req_ready_d[win_idx] = 1'b1;
          snoop_valid_d        = 1'b1;
          snoop_id_d           = win_idx;
          snoop_addr_d         = win_addr;
          snoop_write_d        = win_write;
          mem_req_valid_d      = 1'b1;
          mem_req_addr_d       = win_addr;
          mem_req_write_d      = win_write;
          mem_req_data_d       = win_data;
          state_d              = win_write ? WRITE : READ_WAIT;
        end
      end
      WRITE: begin
        mem_req_valid_d     = 1'b0;
        resp_valid_d[gnt_q] = 1'b1;
        state_d             = IDLE;
      end
      READ_WAIT: begin
        // A response arriving on the last allowed cycle still counts as success.
        if (mem_resp_valid) begin
          resp_data_d         = mem_resp_data;
          resp_valid_d[gnt_q] = 1'b1;
          mem_req_valid_d     = 1'b0;
          timeout_d           = '0;
          state_d             = IDLE;
        end else if (timeout_q == TO_LAST) begin
          resp_valid_d[gnt_q] = 1'b1;
          resp_error_d        = 1'b1;
          mem_req_valid_d     = 1'b0;
          timeout_d           = '0;
          state_d             = IDLE;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      rr_q            <= LAST_ID;
      gnt_q           <= '0;
      timeout_q       <= '0;
      req_ready_q     <= '0;
      resp_valid_q    <= '0;
      resp_error_q    <= 1'b0;
      resp_data_q     <= '0;
      snoop_valid_q   <= 1'b0;
      snoop_id_q      <= '0;
      snoop_addr_q    <= '0;
      snoop_write_q   <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_write_q <= 1'b0;
      mem_req_data_q  <= '0;
    end else begin
      state_q         <= state_d;
      rr_q            <= rr_d;
      gnt_q           <= gnt_d;
      timeout_q       <= timeout_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_error_q    <= resp_error_d;
      resp_data_q     <= resp_data_d;
      snoop_valid_q   <= snoop_valid_d;
      snoop_id_q      <= snoop_id_d;
      snoop_addr_q    <= snoop_addr_d;
      snoop_write_q   <= snoop_write_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_write_q <= mem_req_write_d;
      mem_req_data_q  <= mem_req_data_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_error    = resp_error_q;
  assign resp_data     = resp_data_q;
  assign snoop_valid   = snoop_valid_q;
  assign snoop_id      = snoop_id_q;
  assign snoop_addr    = snoop_addr_q;
  assign snoop_write   = snoop_write_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_write = mem_req_write_q;
  assign mem_req_data  = mem_req_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter with a 4-cycle-delay Memory model and a response scoreboard.
// Unwritten memory words read back as addr*10.
module tb_mem_bus_arbiter;

  localparam int NC = 4;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NC-1:0]     req_valid = '0;
  logic [NC-1:0]     req_write = '0;
  logic [NC*AW-1:0]  req_addr = '0;
  logic [NC*DW-1:0]  req_data = '0;
  logic [NC-1:0]     req_ready;
  logic [NC-1:0]     resp_valid;
  logic              resp_error;
  logic [DW-1:0]     resp_data;
  logic              snoop_valid;
  logic [1:0]        snoop_id;
  logic [AW-1:0]     snoop_addr;
  logic              snoop_write;
  logic              mem_req_valid;
  logic [AW-1:0]     mem_req_addr;
  logic              mem_req_write;
  logic [DW-1:0]     mem_req_data;
  logic              mem_resp_valid;
  logic [DW-1:0]     mem_resp_data;

  mem_bus_arbiter #(
    .NUM_CACHES(NC), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_error(resp_error), .resp_data(resp_data),
    .snoop_valid(snoop_valid), .snoop_id(snoop_id), .snoop_addr(snoop_addr), .snoop_write(snoop_write),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_write(mem_req_write),
    .mem_req_data(mem_req_data), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: answers a read on the 5th consecutive cycle of a held read request.
  logic [DW-1:0] mem [0:63];
  logic [63:0]   written = '0;
  int            delay_cnt = 0;
  bit            mem_mute = 1'b0;

  always @(posedge clk) begin
    if (mem_req_valid && mem_req_write) begin
      mem[mem_req_addr]     <= mem_req_data;
      written[mem_req_addr] <= 1'b1;
    end
    if (mem_req_valid && !mem_req_write) delay_cnt <= delay_cnt + 1;
    else delay_cnt <= 0;
  end

  assign mem_resp_valid = mem_req_valid && !mem_req_write && !mem_mute && (delay_cnt == 4);
  assign mem_resp_data  = written[mem_req_addr] ? mem[mem_req_addr] : 32'(mem_req_addr) * 32'd10;

  typedef struct {
    int         port;
    logic [31:0] data;
    logic       err;
    bit         chk_data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) if (req_ready[i]) req_valid[i] = 1'b0;
  endtask

  task automatic set_req(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[p] = 1'b1;
    req_write[p] = w;
    req_addr[p*AW +: AW] = a;
    req_data[p*DW +: DW] = d;
  endtask

  task automatic wait_ready(input int p, input int budget, output int t);
    t = -1;
    for (int k = 0; k < budget && t < 0; k++) begin
      step();
      if (req_ready[p]) t = cyc;
    end
  endtask

  task automatic wait_resp(input int budget, output int t);
    t = -1;
    for (int k = 0; k < budget && t < 0; k++) begin
      step();
      if (resp_valid != '0) t = cyc;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0;
    repeat (3) step();
    checks++;
    if ({req_ready, resp_valid, resp_error, snoop_valid, mem_req_valid} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_strobes: got %b required 0", {req_ready, resp_valid, resp_error, snoop_valid, mem_req_valid});
    end
    checks++;
    if (resp_data !== '0) begin
      failures++;
      $display("[TB] FAIL reset_resp_data: got %h required 0", resp_data);
    end
    checks++;
    if ({snoop_id, snoop_addr, snoop_write, mem_req_addr, mem_req_write, mem_req_data} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_buses: got %h required 0", {snoop_id, snoop_addr, snoop_write, mem_req_addr, mem_req_write, mem_req_data});
    end
    reset = 1'b0;
    repeat (2) step();
    checks++;
    if (mem_req_valid !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("[TB] FAIL idle_quiet: got mem_req_valid=%b req_ready=%b required 0/0", mem_req_valid, req_ready);
    end
  endtask

  task automatic test_single_read();
    int c0, t_ready, t_resp;
    bit held;
    exp_t e;
    sb.delete();
    c0 = cyc;
    set_req(0, 1'b0, 6'd5, '0);
    sb.push_back('{0, 32'd50, 1'b0, 1'b1});
    wait_ready(0, 5, t_ready);
    checks++;
    if (t_ready != c0 + 1) begin
      failures++;
      $display("[TB] FAIL read_ready_cycle: got %0d required %0d", t_ready, c0 + 1);
    end
    checks++;
    if ({snoop_valid, snoop_id, snoop_addr, snoop_write} !== {1'b1, 2'd0, 6'd5, 1'b0}) begin
      failures++;
      $display("[TB] FAIL read_snoop: got v=%b id=%0d addr=%0d w=%b required 1/0/5/0", snoop_valid, snoop_id, snoop_addr, snoop_write);
    end
    held = 1'b1;
    t_resp = -1;
    for (int k = 0; k < 20 && t_resp < 0; k++) begin
      if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_addr !== 6'd5) held = 1'b0;
      step();
      if (resp_valid != '0) t_resp = cyc;
    end
    checks++;
    if (!held) begin
      failures++;
      $display("[TB] FAIL read_mem_req_held: got unstable request required held 1/read/addr 5");
    end
    checks++;
    if (t_resp != t_ready + 5) begin
      failures++;
      $display("[TB] FAIL read_resp_cycle: got %0d required %0d", t_resp, t_ready + 5);
    end
    if (t_resp >= 0 && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (resp_valid !== (NC'(1) << e.port) || resp_data !== e.data || resp_error !== e.err) begin
        failures++;
        $display("[TB] FAIL read_resp: got valid=%b data=%h err=%b required %b/%h/%b", resp_valid, resp_data, resp_error, NC'(1) << e.port, e.data, e.err);
      end
    end
    checks++;
    if (mem_req_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL read_mem_req_drop: got %b required 0", mem_req_valid);
    end
  endtask

  task automatic test_write_then_read();
    int t_ready, t_resp;
    exp_t e;
    sb.delete();
    set_req(2, 1'b1, 6'd9, 32'hDEADBEEF);
    sb.push_back('{2, 32'h0, 1'b0, 1'b0});
    wait_ready(2, 5, t_ready);
    checks++;
    if ({snoop_id, snoop_write, mem_req_valid, mem_req_write, mem_req_data} !== {2'd2, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF}) begin
      failures++;
      $display("[TB] FAIL write_issue: got id=%0d sw=%b mv=%b mw=%b md=%h required 2/1/1/1/deadbeef", snoop_id, snoop_write, mem_req_valid, mem_req_write, mem_req_data);
    end
    step();
    e = sb.pop_front();
    checks++;
    if (resp_valid !== (NC'(1) << e.port) || resp_error !== e.err || mem_req_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL write_ack: got valid=%b err=%b mv=%b required %b/0/0", resp_valid, resp_error, mem_req_valid, NC'(1) << e.port);
    end
    set_req(2, 1'b0, 6'd9, '0);
    sb.push_back('{2, 32'hDEADBEEF, 1'b0, 1'b1});
    step();
    checks++;
    if (req_ready !== 4'b0100 || mem_req_valid !== 1'b1 || cyc != t_ready + 2) begin
      failures++;
      $display("[TB] FAIL read_after_write_grant: got ready=%b mv=%b cyc=%0d required 0100/1/%0d", req_ready, mem_req_valid, cyc, t_ready + 2);
    end
    wait_resp(20, t_resp);
    checks++;
    if (t_resp != t_ready + 7) begin
      failures++;
      $display("[TB] FAIL raw_resp_cycle: got %0d required %0d", t_resp, t_ready + 7);
    end
    if (t_resp >= 0) begin
      e = sb.pop_front();
      checks++;
      if (resp_valid !== (NC'(1) << e.port) || resp_data !== e.data || resp_error !== e.err) begin
        failures++;
        $display("[TB] FAIL raw_data: got valid=%b data=%h err=%b required %b/%h/%b", resp_valid, resp_data, resp_error, NC'(1) << e.port, e.data, e.err);
      end
    end
  endtask

  task automatic test_all_ports();
    int grants[$];
    int n_resp;
    bit onehot_ok;
    exp_t e;
    sb.delete();
    reset = 1'b1;
    for (int i = 0; i < NC; i++) begin
      set_req(i, 1'b0, 6'(10 + i), '0);
      sb.push_back('{i, 32'((10 + i) * 10), 1'b0, 1'b1});
    end
    repeat (2) step();
    reset = 1'b0;
    n_resp = 0;
    onehot_ok = 1'b1;
    for (int k = 0; k < 80 && n_resp < NC; k++) begin
      step();
      if (!$onehot0(resp_valid) || !$onehot0(req_ready)) onehot_ok = 1'b0;
      if (snoop_valid) grants.push_back(int'(snoop_id));
      if (resp_valid != '0 && sb.size() > 0) begin
        n_resp++;
        e = sb.pop_front();
        checks++;
        if (resp_valid !== (NC'(1) << e.port) || resp_data !== e.data || resp_error !== e.err) begin
          failures++;
          $display("[TB] FAIL all_ports_resp%0d: got valid=%b data=%h err=%b required %b/%h/%b", n_resp, resp_valid, resp_data, resp_error, NC'(1) << e.port, e.data, e.err);
        end
      end
    end
    repeat (8) begin
      step();
      if (resp_valid != '0 || snoop_valid) onehot_ok = 1'b0;
    end
    checks++;
    if (n_resp != NC || grants.size() != NC) begin
      failures++;
      $display("[TB] FAIL all_ports_count: got resp=%0d grants=%0d required %0d/%0d", n_resp, grants.size(), NC, NC);
    end
    for (int i = 0; i < grants.size() && i < NC; i++) begin
      checks++;
      if (grants[i] != i) begin
        failures++;
        $display("[TB] FAIL all_ports_order%0d: got %0d required %0d", i, grants[i], i);
      end
    end
    checks++;
    if (!onehot_ok) begin
      failures++;
      $display("[TB] FAIL all_ports_onehot: got multi-hot or extra strobe required single strobes");
    end
  endtask

  task automatic test_alternate();
    int grants[$];
    int order[4] = '{1, 3, 1, 3};
    int n_resp;
    exp_t e;
    sb.delete();
    reset = 1'b1;
    req_valid = '0;
    step();
    reset = 1'b0;
    set_req(1, 1'b0, 6'd7, '0);
    set_req(3, 1'b0, 6'd3, '0);
    for (int i = 0; i < 4; i++) sb.push_back('{order[i], 32'(order[i] == 1 ? 70 : 30), 1'b0, 1'b1});
    n_resp = 0;
    for (int k = 0; k < 100 && n_resp < 4; k++) begin
      step();
      if (snoop_valid) grants.push_back(int'(snoop_id));
      if (resp_valid != '0 && sb.size() > 0) begin
        n_resp++;
        e = sb.pop_front();
        checks++;
        if (resp_valid !== (NC'(1) << e.port) || resp_data !== e.data) begin
          failures++;
          $display("[TB] FAIL alt_resp%0d: got valid=%b data=%h required %b/%h", n_resp, resp_valid, resp_data, NC'(1) << e.port, e.data);
        end
        if (n_resp <= 2 && resp_valid[1]) set_req(1, 1'b0, 6'd7, '0);
        if (n_resp <= 2 && resp_valid[3]) set_req(3, 1'b0, 6'd3, '0);
      end
    end
    checks++;
    if (grants.size() != 4) begin
      failures++;
      $display("[TB] FAIL alt_grant_count: got %0d required 4", grants.size());
    end
    for (int i = 0; i < grants.size() && i < 4; i++) begin
      checks++;
      if (grants[i] != order[i]) begin
        failures++;
        $display("[TB] FAIL alt_order%0d: got %0d required %0d", i, grants[i], order[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int t_ready, t_resp;
    exp_t e;
    sb.delete();
    set_req(1, 1'b0, 6'd4, '0);
    wait_ready(1, 5, t_ready);
    wait_resp(20, t_resp);
    checks++;
    if (resp_data !== 32'd40) begin
      failures++;
      $display("[TB] FAIL timeout_preload: got %h required %h", resp_data, 32'd40);
    end
    mem_mute = 1'b1;
    set_req(0, 1'b0, 6'd1, '0);
    sb.push_back('{0, 32'd40, 1'b1, 1'b1});
    wait_ready(0, 5, t_ready);
    wait_resp(30, t_resp);
    checks++;
    if (t_resp != t_ready + TO) begin
      failures++;
      $display("[TB] FAIL timeout_cycle: got %0d required %0d", t_resp, t_ready + TO);
    end
    if (t_resp >= 0) begin
      e = sb.pop_front();
      checks++;
      if (resp_valid !== (NC'(1) << e.port) || resp_error !== e.err || resp_data !== e.data || mem_req_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL timeout_resp: got valid=%b err=%b data=%h mv=%b required %b/1/%h/0", resp_valid, resp_error, resp_data, mem_req_valid, NC'(1) << e.port, e.data);
      end
    end
    mem_mute = 1'b0;
    set_req(0, 1'b0, 6'd2, '0);
    sb.push_back('{0, 32'd20, 1'b0, 1'b1});
    step();
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL timeout_back_to_idle: got ready=%b required 0001", req_ready);
    end
    wait_resp(20, t_resp);
    if (t_resp >= 0) begin
      e = sb.pop_front();
      checks++;
      if (resp_data !== e.data || resp_error !== e.err) begin
        failures++;
        $display("[TB] FAIL timeout_recovery: got data=%h err=%b required %h/%b", resp_data, resp_error, e.data, e.err);
      end
    end else begin
      checks++;
      failures++;
      $display("[TB] FAIL timeout_recovery: got no response required one");
    end
  endtask

  task automatic test_reset_mid();
    int t_ready, t_resp;
    bit stray;
    exp_t e;
    sb.delete();
    mem_mute = 1'b1;
    set_req(0, 1'b0, 6'd3, '0);
    wait_ready(0, 5, t_ready);
    repeat (2) step();
    reset = 1'b1;
    step();
    checks++;
    if ({req_ready, resp_valid, resp_error, resp_data, snoop_valid, snoop_id, snoop_addr, snoop_write,
         mem_req_valid, mem_req_addr, mem_req_write, mem_req_data} !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs: got mv=%b ready=%b resp=%b data=%h required all 0", mem_req_valid, req_ready, resp_valid, resp_data);
    end
    reset = 1'b0;
    mem_mute = 1'b0;
    stray = 1'b0;
    repeat (12) begin
      step();
      if (resp_valid != '0 || mem_req_valid) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      failures++;
      $display("[TB] FAIL mid_reset_dropped: got activity after reset required none");
    end
    set_req(0, 1'b0, 6'd6, '0);
    sb.push_back('{0, 32'd60, 1'b0, 1'b1});
    wait_ready(0, 5, t_ready);
    wait_resp(20, t_resp);
    checks++;
    if (t_resp < 0 || t_resp != t_ready + 5) begin
      failures++;
      $display("[TB] FAIL mid_reset_fresh_cycle: got %0d required %0d", t_resp, t_ready + 5);
    end
    if (t_resp >= 0) begin
      e = sb.pop_front();
      checks++;
      if (resp_valid !== (NC'(1) << e.port) || resp_data !== e.data || resp_error !== e.err) begin
        failures++;
        $display("[TB] FAIL mid_reset_fresh: got valid=%b data=%h err=%b required %b/%h/%b", resp_valid, resp_data, resp_error, NC'(1) << e.port, e.data, e.err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_then_read();
    test_all_ports();
    test_alternate();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
